// File: rtl/argmax_pkg.sv
// Shared helpers for the argmax blocks: constant log2 and frame word offsets.
package argmax_pkg;

    function automatic int flog2(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        while (x > 1) begin
            x = x >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int word_lo(input int k, input int m);
        return k * m;
    endfunction

endpackage

// File: rtl/argmax_packer.sv
// Packs N serial M-bit words into one registered M*N-bit frame for the argmax bus.
// Optional short frames (s_last / m_count) under ARGMAX_PACKER_SHORT_FRAME_EN.
module argmax_packer
    import argmax_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [M-1:0]         s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
    input  logic                 s_last,
    output logic [flog2(N):0]    m_count,
`endif
    output logic [M*N-1:0]       m_data
);

    localparam int CW = flog2(N) + 1;
    localparam logic [CW-1:0] LAST_POS = CW'(N - 1);

    logic [CW-1:0]        cnt;
    logic [M*(N-1)-1:0]   fill;
    logic [M*N-1:0]       fill_ext;
    logic [M*N-1:0]       frame_next;
    logic                 close_word;
    logic                 accept;

`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
    assign close_word = (cnt == LAST_POS) || s_last;
`else
    assign close_word = (cnt == LAST_POS);
`endif

    // Only a closing word can stall; earlier words land in the fill buffer.
    assign s_ready  = !(close_word && m_valid && !m_ready);
    assign accept   = s_valid && s_ready;
    assign fill_ext = {{M{1'b0}}, fill};

    // Positions above the closing word are zero (only reachable on short frames).
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(cnt)) begin
                frame_next[word_lo(k, M) +: M] = fill_ext[word_lo(k, M) +: M];
            end else if (k == int'(cnt)) begin
                frame_next[word_lo(k, M) +: M] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            fill    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
            m_count <= '0;
`endif
        end else begin
            if (accept && close_word) begin
                cnt     <= '0;
                m_valid <= 1'b1;
                m_data  <= frame_next;
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
                m_count <= cnt + 1'b1;
`endif
            end else begin
                if (accept) begin
                    cnt <= cnt + 1'b1;
                end
                if (m_ready) begin
                    m_valid <= 1'b0;
                end
            end
            for (int k = 0; k < N - 1; k++) begin
                if (accept && !close_word && cnt == CW'(k)) begin
                    fill[word_lo(k, M) +: M] <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_argmax_packer.sv
// Directed bench for argmax_packer (N=4, M=8) with a frame scoreboard on the output.
module tb_argmax_packer;

    localparam int N = 4;
    localparam int M = 8;

    logic           clk;
    logic           rst;
    logic           s_valid;
    logic           s_ready;
    logic [M-1:0]   s_data;
    logic           m_valid;
    logic           m_ready;
    logic [M*N-1:0] m_data;
    logic           s_last_r;
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
    logic [2:0]     m_count;
    logic [2:0]     cq[$];
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] q[$];
    logic [7:0]  mfill[N];
    int          mcnt;
    logic        hold_prev;
    logic [31:0] prev_data;
    logic        bb_mode;

    argmax_packer #(.N(N), .M(M)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
        .s_last  (s_last_r),
        .m_count (m_count),
`endif
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic        exp_valid;
        logic        closing;
        logic        exp_ready;
        logic [31:0] frame;
        if (rst) begin
            q.delete();
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
            cq.delete();
`endif
            mcnt      = 0;
            hold_prev = 1'b0;
        end else begin
            exp_valid = (q.size() > 0);
            closing   = (mcnt == N - 1) || s_last_r;
            exp_ready = !(closing && exp_valid && !m_ready);
            chk("s_ready", s_ready, exp_ready);
            chk("m_valid", m_valid, exp_valid);
            if (exp_valid) begin
                chk("m_data", m_data, q[0]);
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
                chk("m_count", m_count, cq[0]);
`endif
            end
            if (hold_prev) chk("hold_data", m_data, prev_data);
            hold_prev = exp_valid && !m_ready;
            prev_data = m_data;
            if (exp_valid && m_ready) begin
                void'(q.pop_front());
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
                void'(cq.pop_front());
`endif
            end
            if (s_valid && exp_ready) begin
                if (closing) begin
                    frame = '0;
                    for (int k = 0; k < N; k++) begin
                        if (k < mcnt) frame[k*8 +: 8] = mfill[k];
                        else if (k == mcnt) frame[k*8 +: 8] = s_data;
                    end
                    q.push_back(frame);
`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
                    cq.push_back(3'(mcnt + 1));
`endif
                    mcnt = 0;
                end else begin
                    mfill[mcnt] = s_data;
                    mcnt = mcnt + 1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        logic done;
        done     = 1'b0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last_r = last;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bb_mode && i == 0) chk("bb_ready", s_ready, 1'b1);
            if (s_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 1'b0, 1'b1);
        s_valid  = 1'b0;
        s_last_r = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last_r = 1'b0;
        m_ready  = 1'b1;
        bb_mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_s_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single frame, latency checked right after the closing accept.
        send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0); send(8'd7, 1'b0);
        @(negedge clk);
        chk("t1_valid", m_valid, 1'b1);
        chk("t1_data", m_data, 32'h07010903);
        @(posedge clk);
        #1;

        // Back-to-back frames with continuous valid.
        bb_mode = 1'b1;
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
        bb_mode = 1'b0;
        m_ready = 1'b0;

        // Backpressure: closing word stalls until the pending frame leaves.
        send(8'd21, 1'b0); send(8'd22, 1'b0); send(8'd23, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'd24;
        @(negedge clk);
        chk("t3_stall", s_ready, 1'b0);
        chk("t3_pending", m_data, 32'h0C0B0A09);
        idle(0);
        s_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("t3_release", s_ready, 1'b1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        chk("t3_no_gap", m_valid, 1'b1);
        chk("t3_next", m_data, 32'h18171615);
        @(posedge clk);
        #1;

        // Mid-frame reset drops the partial frame.
        send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'd4, 1'b0); send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b0);
        @(negedge clk);
        chk("t4_data", m_data, 32'h07060504);
        @(posedge clk);
        #1;

        // Bubbles between words.
        send(8'hFF, 1'b0); idle(1);
        send(8'h00, 1'b0); idle(1);
        send(8'h80, 1'b0); idle(1);
        send(8'h01, 1'b0);
        @(negedge clk);
        chk("t5_data", m_data, 32'h018000FF);
        @(posedge clk);
        #1;

`ifdef ARGMAX_PACKER_SHORT_FRAME_EN
        send(8'd5, 1'b0); send(8'd6, 1'b1);
        @(negedge clk);
        chk("t6_short", m_data, 32'h00000605);
        chk("t6_count", m_count, 3'd2);
        @(posedge clk);
        #1;
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        @(negedge clk);
        chk("t6_full_count", m_count, 3'd4);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        chk("drain", 64'(q.size()), 64'd0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/argmax_packer.md
Name: argmax_packer

Overview:
- Upstream feeder for the combinational N-way argmax stage.
- Accepts a serial stream of M-bit unsigned words on a valid/ready interface.
- Packs each group of N consecutive words into one registered flat M*N-bit frame and presents it, with valid/ready, to the argmax input bus.
- Sustains one word per cycle, so one frame leaves every N cycles under continuous traffic.

Parameters:
- N, 8, words per frame (number of argmax inputs); legal range 2..256.
- M, 8, word bit-width; legal range >= 1.
- CW, derived localparam (not overridable), frame-position counter width = floor(log2(N))+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  packer can accept a word this cycle.
- s_data  input  M  input word, unsigned.
- m_valid  output  1  packed frame valid.
- m_ready  input  1  downstream accepts the frame.
- m_data  output  M*N  packed frame; word k of the frame at bits [(k+1)*M-1 : k*M].

Behaviour:
- Reset (clk/rst only, synchronous, active-high):
  - cnt=0, m_valid=0, m_data=0, fill buffer=0.
  - s_ready=1 in the first cycle after reset.
  - Reset mid-frame discards all partially collected words and any pending output frame, with no partial emission.
- Input transfer: s_valid & s_ready at a rising edge.
- Output transfer: m_valid & m_ready at a rising edge.
- Storage:
  - Fill buffer holds N-1 words, positions 0..N-2.
  - Output register holds M*N bits.
  - cnt (CW bits) is the position of the next accepted word, range 0..N-1.
- Accept with cnt<N-1: write s_data into fill position cnt; cnt<=cnt+1.
- Accept with cnt==N-1 (the closing word):
  - m_data <= {s_data, fill[N-2..0]}; m_valid<=1; cnt<=0.
  - The closing word goes straight to the output register, bypassing the fill buffer.
- s_ready = !(cnt==N-1 && m_valid && !m_ready).
  - Only the closing word ever stalls.
  - Words 0..N-2 of the next frame are accepted while the previous frame waits.
- Simultaneous closing-word accept and output transfer: the new frame replaces the old one and m_valid stays 1. No bubble and no loss.
- Output transfer with no closing-word accept: m_valid<=0. m_data holds its value; it is don't-care while m_valid=0.
- Hold: while m_valid & !m_ready, m_data and m_valid stay stable (AXI-style). m_valid never deasserts without a transfer.
- s_valid low: cnt and buffers hold; no timeout.
- Latency: m_valid rises on the cycle after the closing word is accepted.
- Counter wrap: N-1 -> 0 only on the closing accept; cnt never reaches N.
- s_ready must not depend combinationally on s_valid.
- The m_ready -> s_ready combinational path is permitted (single gate).

Optional Feature:
- Macro: ARGMAX_PACKER_SHORT_FRAME_EN.
- Defined:
  - Adds input s_last (1 bit) and output m_count (CW bits).
  - An accepted word with s_last=1 closes the frame regardless of cnt.
  - Positions above the closing word are zero-filled.
  - m_count = number of real words (cnt+1 at the closing accept), registered with m_data.
  - s_last on position N-1 behaves as a normal full frame with m_count=N.
  - The stall rule applies to any closing word.
  - Reset clears m_count to 0.
- Undefined: no s_last or m_count ports; frames are always exactly N words. Core logic is otherwise identical.

Decomposition:
- Shared package argmax_pkg:
  - the log2 constant function used across the argmax blocks;
  - frame-slice helper (word k offset = k*M).
- No sub-module. Counter, fill buffer and output register live in one module.
- A full-featured skid-buffer sub-module is not needed, since only the closing word stalls.

Test Plan:
1. Reset then stream, N=4 M=8, words 3,9,1,7 with s_valid=1 and m_ready=1 -> m_valid high one cycle after the 4th accept; m_data=0x07010903.
2. Back-to-back: 3 frames (12 words, values 1..12) with s_valid=1 and m_ready=1 -> s_ready constantly 1; frames 0x04030201, 0x08070605, 0x0C0B0A09 on cycles 5, 9 and 13.
3. Backpressure: m_ready=0 after frame 1; send 4 more words -> first 3 accepted; s_ready=0 at cnt=3; m_data stable. Raise m_ready -> closing word accepted in the same cycle as the output transfer; next frame valid on the following cycle, with no gap in m_valid.
4. Mid-frame reset: accept 2 words, assert rst 1 cycle, then send 4,5,6,7 -> frame 0x07060504; the pre-reset words never appear.
5. Bubbles: s_valid toggling 1,0,1,0 over words 0xFF,0x00,0x80,0x01 -> same frame 0x018000FF; cnt holds during gaps.
6. With ARGMAX_PACKER_SHORT_FRAME_EN: words 5,6 with s_last on 6 -> m_data=0x00000605, m_count=2; next full frame has m_count=4.
